// File: rtl/mmio_ctrl_pipe.sv
// Registered FPro MMIO slot controller: decodes bus accesses to N_SLOT slots,
// issues registered per-slot strobes, returns data with a ready pulse and logs errors.
module mmio_ctrl_pipe #(
   parameter int          N_SLOT    = 64,
   parameter logic [63:0] SLOT_MASK = 64'hFFFF_FFFF_FFFF_FFFF,
   parameter int          STAT_SLOT = 63
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mmio_cs,
   input  logic                     mmio_wr,
   input  logic                     mmio_rd,
   input  logic [20:0]              mmio_addr,
   input  logic [31:0]              mmio_wr_data,
   output logic [31:0]              mmio_rd_data,
   output logic                     mmio_ready,
   output logic [N_SLOT-1:0]        slot_cs_array,
   output logic [N_SLOT-1:0]        slot_mem_rd_array,
   output logic [N_SLOT-1:0]        slot_mem_wr_array,
   output logic [N_SLOT-1:0][4:0]   slot_reg_addr_array,
   output logic [N_SLOT-1:0][31:0]  slot_wr_data_array,
   input  logic [N_SLOT-1:0][31:0]  slot_rd_data_array
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2,
      ERR   = 2'd3
   } state_t;

   localparam logic [5:0]  STAT_IDX   = 6'(STAT_SLOT);
   localparam logic [6:0]  N_SLOT_W   = 7'(N_SLOT);
   localparam logic [63:0] SLOT_RANGE = (N_SLOT >= 64) ? {64{1'b1}} : ((64'd1 << N_SLOT) - 64'd1);
   localparam logic [63:0] MASK_EFF   = SLOT_MASK & SLOT_RANGE;

   state_t              state_r;
   logic [20:0]         addr_r;
   logic [31:0]         wr_data_r;
   logic                rd_r;
   logic                wr_r;
   logic [31:0]         rd_data_r;
   logic                ready_r;
   logic [N_SLOT-1:0]   cs_r;
   logic [N_SLOT-1:0]   mem_rd_r;
   logic [N_SLOT-1:0]   mem_wr_r;
   logic [15:0]         err_cnt_r;
   logic [20:0]         last_err_addr_r;

   logic [5:0]          req_slot_s;
   logic                req_valid_s;
   logic                req_is_stat_s;
   logic [N_SLOT-1:0]   req_dec_s;
   logic [5:0]          cur_slot_s;
   logic                cur_is_stat_s;
   logic [N_SLOT-1:0]   cur_dec_s;
   logic [31:0]         rd_mux_s;
   logic [31:0]         stat_rd_s;
   logic                overrun_s;
   logic                clear_s;
   logic [1:0]          inc_s;
   logic [16:0]         err_sum_s;
   logic [15:0]         err_next_s;

   // Classify the incoming request and one-hot decode its slot.
   always_comb begin
      req_slot_s    = mmio_addr[10:5];
      req_is_stat_s = (req_slot_s == STAT_IDX);
      req_valid_s   = (mmio_rd ^ mmio_wr)
                      && ({1'b0, req_slot_s} < N_SLOT_W)
                      && (SLOT_MASK[req_slot_s] || req_is_stat_s);
      for (int i = 0; i < N_SLOT; i++) begin
         req_dec_s[i] = (req_slot_s == 6'(i));
      end
   end

   // Decode the latched access and select the slot read data for the response.
   always_comb begin
      cur_slot_s    = addr_r[10:5];
      cur_is_stat_s = (cur_slot_s == STAT_IDX);
      rd_mux_s      = 32'h0000_0000;
      for (int i = 0; i < N_SLOT; i++) begin
         cur_dec_s[i] = (cur_slot_s == 6'(i));
         if (cur_dec_s[i]) begin
            rd_mux_s = slot_rd_data_array[i];
         end else begin
            rd_mux_s = rd_mux_s;
         end
      end
   end

   // Status register read map.
   always_comb begin
      case (addr_r[4:0])
         5'd0:    stat_rd_s = {16'h0000, err_cnt_r};
         5'd1:    stat_rd_s = {11'h000, last_err_addr_r};
         5'd2:    stat_rd_s = MASK_EFF[31:0];
         default: stat_rd_s = 32'h0000_0000;
      endcase
   end

   // Error counter next value: ERR and overrun may both add one; a clear overrides both.
   always_comb begin
      overrun_s  = mmio_cs && (state_r != IDLE);
      clear_s    = (state_r == ISSUE) && cur_is_stat_s && wr_r && (addr_r[4:0] == 5'd0);
      inc_s      = {1'b0, (state_r == ERR)} + {1'b0, overrun_s};
      err_sum_s  = {1'b0, err_cnt_r} + {15'd0, inc_s};
      if (clear_s) begin
         err_next_s = 16'h0000;
      end else if (err_sum_s[16]) begin
         err_next_s = 16'hFFFF;
      end else begin
         err_next_s = err_sum_s[15:0];
      end
   end

   // Access sequencer with registered strobes, ready and read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r         <= IDLE;
         addr_r          <= 21'd0;
         wr_data_r       <= 32'h0000_0000;
         rd_r            <= 1'b0;
         wr_r            <= 1'b0;
         rd_data_r       <= 32'h0000_0000;
         ready_r         <= 1'b0;
         cs_r            <= {N_SLOT{1'b0}};
         mem_rd_r        <= {N_SLOT{1'b0}};
         mem_wr_r        <= {N_SLOT{1'b0}};
         err_cnt_r       <= 16'h0000;
         last_err_addr_r <= 21'd0;
      end else begin
         ready_r   <= 1'b0;
         cs_r      <= {N_SLOT{1'b0}};
         mem_rd_r  <= {N_SLOT{1'b0}};
         mem_wr_r  <= {N_SLOT{1'b0}};
         err_cnt_r <= err_next_s;
         case (state_r)
            IDLE: begin
               // rd=wr=0 with cs is not an access at all
               if (mmio_cs && (mmio_rd || mmio_wr)) begin
                  addr_r    <= mmio_addr;
                  wr_data_r <= mmio_wr_data;
                  rd_r      <= mmio_rd;
                  wr_r      <= mmio_wr;
                  if (req_valid_s) begin
                     state_r <= ISSUE;
                     if (!req_is_stat_s) begin
                        cs_r     <= req_dec_s;
                        mem_rd_r <= mmio_rd ? req_dec_s : {N_SLOT{1'b0}};
                        mem_wr_r <= mmio_wr ? req_dec_s : {N_SLOT{1'b0}};
                     end
                  end else begin
                     state_r   <= ERR;
                     ready_r   <= 1'b1;
                     rd_data_r <= 32'h0000_0000;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            ISSUE: begin
               ready_r <= 1'b1;
               state_r <= RESP;
               if (rd_r) begin
                  rd_data_r <= cur_is_stat_s ? stat_rd_s : rd_mux_s;
               end
            end
            RESP: begin
               state_r <= IDLE;
            end
            ERR: begin
               last_err_addr_r <= addr_r;
               state_r         <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign mmio_rd_data      = rd_data_r;
   assign mmio_ready        = ready_r;
   assign slot_cs_array     = cs_r;
   assign slot_mem_rd_array = mem_rd_r;
   assign slot_mem_wr_array = mem_wr_r;

   // Register address and write data are broadcast to every slot.
   for (genvar g = 0; g < N_SLOT; g++) begin : g_bcast
      assign slot_reg_addr_array[g] = addr_r[4:0];
      assign slot_wr_data_array[g]  = wr_data_r;
   end

endmodule
